// File: rtl/counter_roll.sv
// counter_roll: wrapping up-counter 0..Max with synchronous clear; clear wins over enable.
module counter_roll #(
    parameter int unsigned Max   = 3,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= (r_count == Width'(Max)) ? '0 : r_count + 1'b1;
        end
    end

    assign q_o = r_count;

endmodule

// File: rtl/packer.sv
// packer: gathers PackedNum narrow items into one registered wide word, first item in the LSBs.
// Build option PACKER_FLUSH_EN adds flush_i, which emits a zero-padded partial word early.
module packer #(
    parameter int unsigned UnpackedWidth = 2,
    parameter int unsigned PackedNum     = 4,
    parameter int unsigned PackedWidth   = UnpackedWidth * PackedNum
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [UnpackedWidth-1:0] unpacked_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [PackedWidth-1:0]   packed_o,
    output logic                     valid_o,
    input  logic                     ready_i
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                     flush_i
`endif
);

    localparam int unsigned CountWidth = $clog2(PackedNum);

    logic [CountWidth-1:0]  w_count;
    logic                   w_last;
    logic                   w_hold_last;
    logic                   w_in_fire;
    logic                   w_flush_fire;
    logic                   w_emit;
    logic [PackedWidth-1:0] w_next_acc;
    logic [PackedWidth-1:0] r_acc;
    logic [PackedWidth-1:0] r_packed;
    logic                   r_valid;

    assign w_last = (w_count == CountWidth'(PackedNum - 1));

`ifdef PACKER_FLUSH_EN
    // A pending flush closes the word, so it must obey the same back-pressure as the last lane.
    assign w_hold_last  = w_last || flush_i;
    assign w_flush_fire = flush_i && ready_o && ((w_count != '0) || w_in_fire);
`else
    assign w_hold_last  = w_last;
    assign w_flush_fire = 1'b0;
`endif

    assign ready_o   = !w_hold_last || !r_valid || ready_i;
    assign w_in_fire = valid_i && ready_o;
    assign w_emit    = (w_in_fire && w_last) || w_flush_fire;

    counter_roll #(
        .Max   (PackedNum - 1),
        .Width (CountWidth)
    ) u_lane_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_in_fire),
        .clr_i  (w_flush_fire),
        .q_o    (w_count)
    );

    // Accumulator with the incoming item merged at the current lane; unwritten lanes stay zero.
    always_comb begin
        w_next_acc = r_acc;
        if (w_in_fire) begin
            for (int unsigned k = 0; k < PackedNum; k++) begin
                if (w_count == CountWidth'(k)) begin
                    w_next_acc[k*UnpackedWidth +: UnpackedWidth] = unpacked_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc    <= '0;
            r_packed <= '0;
            r_valid  <= 1'b0;
        end else if (w_emit) begin
            r_packed <= w_next_acc;
            r_valid  <= 1'b1;
            r_acc    <= '0;
        end else begin
            r_acc <= w_next_acc;
            if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign packed_o = r_packed;
    assign valid_o  = r_valid;

endmodule

// File: doc/packer.md
Name: packer

Overview:
- Inverse of the stream unpacker: gathers PackedNum consecutive narrow items (UnpackedWidth bits each) into one PackedWidth word.
- Sits upstream of wide consumers: memory write ports, UART/SPI TX serialisers, wide FIFOs.
- Ready/valid on both sides; registered output; full throughput of one narrow item per cycle.
- Lane order matches the unpacker, so packer followed by unpacker is an identity stream.

Parameters:
- UnpackedWidth, 2, width of each input item.
- PackedNum, 4, items per packed word; must be >= 2.
- PackedWidth, UnpackedWidth*PackedNum, output width; derived, do not override.
- CountWidth (localparam), $clog2(PackedNum), lane counter width.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_ni, input, 1, asynchronous active-low reset.
- unpacked_i, input, UnpackedWidth, narrow input item.
- valid_i, input, 1, unpacked_i is valid.
- ready_o, output, 1, packer accepts unpacked_i this cycle.
- packed_o, output, PackedWidth, assembled word.
- valid_o, output, 1, packed_o is valid.
- ready_i, input, 1, downstream accepts packed_o.
- flush_i, input, 1, present only with PACKER_FLUSH_EN (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-low. On rst_ni=0: lane counter=0, accumulator=0, output register=0, valid_o=0. ready_o is 1 once reset releases.
- Fire definitions: in_fire = valid_i && ready_o; out_fire = valid_o && ready_i.
- Lane placement: the item accepted at lane k (k = 0..PackedNum-1) lands in bits [k*UnpackedWidth +: UnpackedWidth]. The first item of a word goes in the LSBs.
- Counter: counter_roll instance, max PackedNum-1, increments on in_fire, wraps to 0 after the last lane.
- Last-lane in_fire: {unpacked_i, accumulator lanes 0..PackedNum-2} is loaded into the output register in the same edge. valid_o=1 on the next cycle. The accumulator clears to 0.
- Latency: packed_o/valid_o appear 1 cycle after the PackedNum-th in_fire.
- ready_o = (counter != PackedNum-1) || !valid_o || ready_i.
  - Non-last lanes are always accepted.
  - The last lane is accepted only when the output register is empty or draining this cycle.
- Simultaneous events:
  - out_fire with last-lane in_fire: the output register reloads and valid_o stays 1. No bubble.
  - out_fire alone: valid_o drops to 0 on the next cycle.
- Output stability: packed_o and valid_o are held stable while valid_o && !ready_i. They are pure register outputs with no combinational path from valid_i or ready_i.
- Sustained throughput: 1 item/cycle in, 1 word per PackedNum cycles out, with ready_i held high.
- valid_i low mid-word: the partial accumulator is held indefinitely. Nothing is emitted.
- Reset mid-word: the partial word is discarded. The counter returns to lane 0.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- Defined: adds the flush_i port. flush_i is qualified by ready_o.
  - It forces the current word to be emitted as if the last lane had fired. Lanes not yet written are zero.
  - If in_fire occurs in the same cycle, that item is included at the current lane first.
  - Flush with counter=0 and no in_fire is ignored; no empty word is emitted.
  - After a flush the counter returns to 0.
  - While a flush is pending, ready_o follows the last-lane rule.
- Undefined: no flush_i port. A word is emitted only after exactly PackedNum items.

Decomposition:
- No shared package needed; all constants are derived localparams.
- Reuses the existing counter_roll for the lane counter.
- The output register is inline.
- No new sub-module.

Test Plan:
- Defaults (2-bit items, 4 lanes): inputs 1,2,3,0 on consecutive cycles, ready_i=1 -> packed_o=8'h39 with valid_o=1 exactly 1 cycle after the 4th accept.
- Stream 0..3 repeating for 12 items, ready_i=1 -> three words 8'hE4, ready_o never drops.
- Hold ready_i=0 after the first word, then push 4 more items -> ready_o=0 on the 4th item, packed_o held at 8'hE4. Raise ready_i -> the 4th item is accepted the same cycle and the next word follows with no bubble.
- Pull rst_ni low after 2 items, then push 3,3,3,3 -> output 8'hFF. No remnant of the earlier lanes.
- PACKER_FLUSH_EN: push 1,2 then pulse flush_i -> packed_o=8'h09. A further flush at lane 0 with no data emits nothing.
- Loopback packer->unpacker with random valid/ready stalls, 1000 items -> output sequence identical to the input sequence.
